bank_tracker: RTL and testbench

Parametrised successor of the accounter for the multi-port RAM wrapper. It records, per memory row, which write agent last wrote the row, whether that write collided with another agent, and whether the row has been written since reset or clear. It serves NB_RDAGENT independent read ports with registered lookups and an optional same-cycle write bypass. A flush input and a saturating collision counter support the wrapper's debug and status path.

---
 rtl/bank_tracker_pkg.sv | 20 ++
 rtl/bank_tracker_if.sv | 30 +++
 rtl/bank_tracker_row.sv | 70 +++++++
 rtl/bank_tracker.sv | 128 ++++++++++++
 tb/tb_bank_tracker.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_tracker_pkg.sv
// Shared types and constants for the bank_tracker row table.
package bank_tracker_pkg;

  localparam int unsigned AGENT_MAX_WIDTH = 4;
  localparam int unsigned CNT_WIDTH       = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;

  // One tracked row: written since reset/clear, last write collided, last writer.
  typedef struct packed {
    logic                       written;
    logic                       collision;
    logic [AGENT_MAX_WIDTH-1:0] agent;
  } row_entry_t;

  // Width of an agent index; at least one bit even for a single agent.
  function automatic int unsigned agent_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $unsigned($clog2(n));
  endfunction

endpackage

// File: rtl/bank_tracker_if.sv
// Write/lookup bus of bank_tracker: write strobes, read lookups and status.
interface bank_tracker_if #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned NB_WRAGENT  = 2,
  parameter int unsigned NB_RDAGENT  = 2,
  parameter int unsigned AGENT_WIDTH = bank_tracker_pkg::agent_width(NB_WRAGENT)
);

  logic                                      clear;
  logic [NB_WRAGENT-1:0]                     wren;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0]          wraddr;
  logic [NB_RDAGENT-1:0]                     rden;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]          rdaddr;
  logic [NB_RDAGENT-1:0]                     rdvalid;
  logic [NB_RDAGENT*AGENT_WIDTH-1:0]         bank_select;
  logic [NB_RDAGENT-1:0]                     rd_collision;
  logic [NB_RDAGENT-1:0]                     rd_hit;
  logic [bank_tracker_pkg::CNT_WIDTH-1:0]    collision_cnt;

  modport master (
    output clear, wren, wraddr, rden, rdaddr,
    input  rdvalid, bank_select, rd_collision, rd_hit, collision_cnt
  );

  modport slave (
    input  clear, wren, wraddr, rden, rdaddr,
    output rdvalid, bank_select, rd_collision, rd_hit, collision_cnt
  );

endinterface

// File: rtl/bank_tracker_row.sv
// One tracked row: resolves this cycle's writers and holds the row entry.
module bank_tracker_row
  import bank_tracker_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned NB_WRAGENT      = 2,
  parameter int unsigned WRITE_COLLISION = 1,
  parameter int unsigned ROW             = 0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           clear,
  input  logic [NB_WRAGENT-1:0]          wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  output row_entry_t                     entry,
  output row_entry_t                     wr_entry,
  output logic                           wr_hit,
  output logic                           coll_pulse
);

  localparam logic [ADDR_WIDTH-1:0] ROW_ADDR = ADDR_WIDTH'(ROW);

  row_entry_t                 entry_d, entry_q;
  logic                       hit, multi;
  logic [AGENT_MAX_WIDTH-1:0] winner;

  // Priority encode matching writers: lowest index wins, any further match is a collision.
  always_comb begin
    hit    = 1'b0;
    multi  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
      if (wren[i] && (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ROW_ADDR)) begin
        if (hit) begin
          multi = 1'b1;
        end else begin
          winner = AGENT_MAX_WIDTH'(i);
        end
        hit = 1'b1;
      end
    end
  end

  // Next row state: clear wins over writes, unmatched rows hold.
  always_comb begin
    wr_entry.written   = 1'b1;
    wr_entry.collision = multi && (WRITE_COLLISION != 0);
    wr_entry.agent     = winner;
    entry_d            = entry_q;
    if (clear) begin
      entry_d = '0;
    end else if (hit) begin
      entry_d = wr_entry;
    end
  end

  // Row register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry      = entry_q;
  assign wr_hit     = hit;
  assign coll_pulse = multi && (WRITE_COLLISION != 0);

endmodule

// File: rtl/bank_tracker.sv
// Per-row last-writer tracker with independent registered read ports,
// optional same-cycle write bypass and a saturating collision counter.
module bank_tracker
  import bank_tracker_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned RAM_DEPTH       = 2**ADDR_WIDTH,
  parameter int unsigned NB_WRAGENT      = 2,
  parameter int unsigned NB_RDAGENT      = 2,
  parameter int unsigned WRITE_COLLISION = 1,
  parameter int unsigned BYPASS          = 1,
  parameter int unsigned AGENT_WIDTH     = agent_width(NB_WRAGENT)
) (
  input  logic           aclk,
  input  logic           aresetn,
  bank_tracker_if.slave  bus
);

  row_entry_t             row_q  [RAM_DEPTH];
  row_entry_t             row_wr [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]   row_wr_hit;
  logic [RAM_DEPTH-1:0]   row_coll;

  logic [ADDR_WIDTH-1:0]  rd_addr [NB_RDAGENT];
  row_entry_t             rd_sel  [NB_RDAGENT];
  logic                   unused_rd_sel;

  logic [CNT_WIDTH-1:0]              cnt_d, cnt_q;
  logic [NB_RDAGENT-1:0]             rdvalid_d, rdvalid_q;
  logic [NB_RDAGENT*AGENT_WIDTH-1:0] bank_select_d, bank_select_q;
  logic [NB_RDAGENT-1:0]             rd_collision_d, rd_collision_q;
  logic [NB_RDAGENT-1:0]             rd_hit_d, rd_hit_q;

  // Rows beyond RAM_DEPTH are never built, so out-of-range writes fall away naturally.
  for (genvar g = 0; g < RAM_DEPTH; g++) begin : g_row
    bank_tracker_row #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .NB_WRAGENT      (NB_WRAGENT),
      .WRITE_COLLISION (WRITE_COLLISION),
      .ROW             (g)
    ) u_row (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .clear      (bus.clear),
      .wren       (bus.wren),
      .wraddr     (bus.wraddr),
      .entry      (row_q[g]),
      .wr_entry   (row_wr[g]),
      .wr_hit     (row_wr_hit[g]),
      .coll_pulse (row_coll[g])
    );
  end

  for (genvar g = 0; g < NB_RDAGENT; g++) begin : g_rdaddr
    assign rd_addr[g] = bus.rdaddr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Collision counter: one step per cycle with any colliding row, saturating, zeroed by clear.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clear) begin
      cnt_d = '0;
    end else if ((|row_coll) && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Read muxes: bypass picks the resolved write unless clear has dropped it.
  always_comb begin
    for (int unsigned r = 0; r < NB_RDAGENT; r++) begin
      rd_sel[r] = '0;
      if (32'(rd_addr[r]) < RAM_DEPTH) begin
        if ((BYPASS != 0) && !bus.clear && row_wr_hit[rd_addr[r]]) begin
          rd_sel[r] = row_wr[rd_addr[r]];
        end else begin
          rd_sel[r] = row_q[rd_addr[r]];
        end
      end
    end
  end

  // Agent bits above AGENT_WIDTH are always zero; sink them so nothing dangles.
  always_comb begin
    unused_rd_sel = 1'b0;
    for (int unsigned r = 0; r < NB_RDAGENT; r++) begin
      unused_rd_sel = unused_rd_sel ^ (^rd_sel[r]);
    end
  end

  // Output staging: valid follows rden, data loads only on a lookup and otherwise holds.
  always_comb begin
    rdvalid_d      = bus.rden;
    bank_select_d  = bank_select_q;
    rd_collision_d = rd_collision_q;
    rd_hit_d       = rd_hit_q;
    for (int unsigned r = 0; r < NB_RDAGENT; r++) begin
      if (bus.rden[r]) begin
        bank_select_d[r*AGENT_WIDTH +: AGENT_WIDTH] = rd_sel[r].agent[AGENT_WIDTH-1:0];
        rd_collision_d[r] = rd_sel[r].collision;
        rd_hit_d[r]       = rd_sel[r].written;
      end
    end
  end

  // Output and counter registers; reset discards any in-flight lookup.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q          <= '0;
      rdvalid_q      <= '0;
      bank_select_q  <= '0;
      rd_collision_q <= '0;
      rd_hit_q       <= '0;
    end else begin
      cnt_q          <= cnt_d;
      rdvalid_q      <= rdvalid_d;
      bank_select_q  <= bank_select_d;
      rd_collision_q <= rd_collision_d;
      rd_hit_q       <= rd_hit_d;
    end
  end

  assign bus.collision_cnt = cnt_q;
  assign bus.rdvalid       = rdvalid_q;
  assign bus.bank_select   = bank_select_q;
  assign bus.rd_collision  = rd_collision_q;
  assign bus.rd_hit        = rd_hit_q;

endmodule

// File: tb/tb_bank_tracker.sv
// Self-checking bench for bank_tracker: one bypass and one non-bypass
// instance share stimulus and are compared against a behavioural table model.
module tb_bank_tracker;

  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int NWR   = 3;
  localparam int NRD   = 2;
  localparam int AGW   = 2;

  logic aclk;
  logic aresetn;

  bank_tracker_if #(.ADDR_WIDTH(AW), .NB_WRAGENT(NWR), .NB_RDAGENT(NRD), .AGENT_WIDTH(AGW)) bus_b ();
  bank_tracker_if #(.ADDR_WIDTH(AW), .NB_WRAGENT(NWR), .NB_RDAGENT(NRD), .AGENT_WIDTH(AGW)) bus_n ();

  assign bus_n.clear  = bus_b.clear;
  assign bus_n.wren   = bus_b.wren;
  assign bus_n.wraddr = bus_b.wraddr;
  assign bus_n.rden   = bus_b.rden;
  assign bus_n.rdaddr = bus_b.rdaddr;

  bank_tracker #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NB_WRAGENT(NWR), .NB_RDAGENT(NRD),
    .WRITE_COLLISION(1), .BYPASS(1), .AGENT_WIDTH(AGW)
  ) dut_b (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus_b)
  );

  bank_tracker #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NB_WRAGENT(NWR), .NB_RDAGENT(NRD),
    .WRITE_COLLISION(1), .BYPASS(0), .AGENT_WIDTH(AGW)
  ) dut_n (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus_n)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Reference table
  int  m_agent [DEPTH];
  bit  m_col   [DEPTH];
  bit  m_wr    [DEPTH];
  int  m_cnt;

  logic [NRD-1:0]     e_valid;
  logic [NRD*AGW-1:0] e_bs_b, e_bs_n;
  logic [NRD-1:0]     e_col_b, e_hit_b, e_col_n, e_hit_n;
  logic [15:0]        e_cnt;

  int n_tests;
  int n_fail;

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      m_agent[a] = 0;
      m_col[a]   = 1'b0;
      m_wr[a]    = 1'b0;
    end
    m_cnt   = 0;
    e_valid = '0;
    e_bs_b  = '0;
    e_bs_n  = '0;
    e_col_b = '0;
    e_hit_b = '0;
    e_col_n = '0;
    e_hit_n = '0;
    e_cnt   = '0;
  endtask

  task automatic set_idle();
    bus_b.clear  = 1'b0;
    bus_b.wren   = '0;
    bus_b.wraddr = '0;
    bus_b.rden   = '0;
    bus_b.rdaddr = '0;
  endtask

  // Who writes address a this cycle: count the matching agents, lowest one wins.
  function automatic void resolve(input int a, output bit hit, output int ag, output bit col);
    int n;
    n   = 0;
    hit = 1'b0;
    ag  = 0;
    col = 1'b0;
    if (a < DEPTH) begin
      for (int i = 0; i < NWR; i++) begin
        if (bus_b.wren[i] && int'(bus_b.wraddr[i*AW +: AW]) == a) begin
          if (n == 0) ag = i;
          n++;
        end
      end
      hit = (n > 0);
      col = (n >= 2);
    end
  endfunction

  // Predict this cycle's lookups and table update, then let the clock edge happen.
  task automatic advance();
    bit h, c, any_col;
    int ag, a;
    for (int r = 0; r < NRD; r++) begin
      if (bus_b.rden[r]) begin
        a = int'(bus_b.rdaddr[r*AW +: AW]);
        if (a >= DEPTH) begin
          e_bs_b[r*AGW +: AGW] = '0; e_col_b[r] = 1'b0; e_hit_b[r] = 1'b0;
          e_bs_n[r*AGW +: AGW] = '0; e_col_n[r] = 1'b0; e_hit_n[r] = 1'b0;
        end else begin
          e_bs_n[r*AGW +: AGW] = AGW'(m_agent[a]);
          e_col_n[r] = m_col[a];
          e_hit_n[r] = m_wr[a];
          resolve(a, h, ag, c);
          if (h && !bus_b.clear) begin
            e_bs_b[r*AGW +: AGW] = AGW'(ag);
            e_col_b[r] = c;
            e_hit_b[r] = 1'b1;
          end else begin
            e_bs_b[r*AGW +: AGW] = AGW'(m_agent[a]);
            e_col_b[r] = m_col[a];
            e_hit_b[r] = m_wr[a];
          end
        end
      end
    end
    e_valid = bus_b.rden;
    if (bus_b.clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_agent[k] = 0; m_col[k] = 1'b0; m_wr[k] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      any_col = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        if (bus_b.wren[i]) begin
          a = int'(bus_b.wraddr[i*AW +: AW]);
          resolve(a, h, ag, c);
          if (h) begin
            m_agent[a] = ag; m_col[a] = c; m_wr[a] = 1'b1;
            any_col = any_col | c;
          end
        end
      end
      if (any_col && m_cnt < 65535) m_cnt++;
    end
    e_cnt = 16'(m_cnt);
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(200, 255));
    return AW'($urandom_range(0, 11));
  endfunction

  task automatic test_reset();
    aresetn = 1'b0;
    set_idle();
    model_reset();
    #3;
    n_tests++;
    if ({bus_b.rdvalid, bus_b.bank_select, bus_b.rd_collision, bus_b.rd_hit, bus_b.collision_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got v=%b bs=%h c=%b h=%b cnt=%h, want all zero",
               bus_b.rdvalid, bus_b.bank_select, bus_b.rd_collision, bus_b.rd_hit, bus_b.collision_cnt);
    end
    n_tests++;
    if ({bus_n.rdvalid, bus_n.bank_select, bus_n.rd_collision, bus_n.rd_hit, bus_n.collision_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_n: got v=%b bs=%h c=%b h=%b cnt=%h, want all zero",
               bus_n.rdvalid, bus_n.bank_select, bus_n.rd_collision, bus_n.rd_hit, bus_n.collision_cnt);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int pass = 0; pass < 3; pass++) begin
      bus_b.rden   = 2'b11;
      bus_b.rdaddr = (pass == 0) ? {8'd199, 8'd0} : (pass == 1) ? {8'd0, 8'd199} : {8'd255, 8'd200};
      advance();
      n_tests++;
      if (bus_b.rdvalid !== 2'b11 || bus_b.bank_select !== 4'h0 || bus_b.rd_hit !== 2'b00 ||
          bus_b.rd_collision !== 2'b00 || bus_b.collision_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_read_b pass%0d: got v=%b bs=%h c=%b h=%b cnt=%h, want v=11 bs=0 c=00 h=00 cnt=0",
                 pass, bus_b.rdvalid, bus_b.bank_select, bus_b.rd_collision, bus_b.rd_hit, bus_b.collision_cnt);
      end
      n_tests++;
      if (bus_n.rdvalid !== 2'b11 || bus_n.bank_select !== 4'h0 || bus_n.rd_hit !== 2'b00 ||
          bus_n.rd_collision !== 2'b00 || bus_n.collision_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_read_n pass%0d: got v=%b bs=%h c=%b h=%b cnt=%h, want v=11 bs=0 c=00 h=00 cnt=0",
                 pass, bus_n.rdvalid, bus_n.bank_select, bus_n.rd_collision, bus_n.rd_hit, bus_n.collision_cnt);
      end
    end
    set_idle();
    advance();
    n_tests++;
    if (bus_b.rdvalid !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_valid: got %b, want 00", bus_b.rdvalid);
    end
  endtask

  task automatic test_write_read();
    set_idle();
    bus_b.wren   = 3'b010;
    bus_b.wraddr = {8'd0, 8'd5, 8'd0};
    advance();
    set_idle();
    bus_b.rden   = 2'b01;
    bus_b.rdaddr = {8'd0, 8'd5};
    advance();
    n_tests++;
    if (bus_b.rdvalid !== 2'b01 || bus_b.bank_select[1:0] !== 2'd1 || bus_b.rd_hit[0] !== 1'b1 ||
        bus_b.rd_collision[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL write_read_b: got v=%b bs=%0d h=%b c=%b, want v=01 bs=1 h=1 c=0",
               bus_b.rdvalid, bus_b.bank_select[1:0], bus_b.rd_hit[0], bus_b.rd_collision[0]);
    end
    n_tests++;
    if (bus_n.bank_select[1:0] !== 2'd1 || bus_n.rd_hit[0] !== 1'b1 || bus_n.rd_collision[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL write_read_n: got bs=%0d h=%b c=%b, want bs=1 h=1 c=0",
               bus_n.bank_select[1:0], bus_n.rd_hit[0], bus_n.rd_collision[0]);
    end
  endtask

  task automatic test_collision();
    set_idle();
    bus_b.wren   = 3'b101;
    bus_b.wraddr = {8'd9, 8'd0, 8'd9};
    advance();
    n_tests++;
    if (bus_b.collision_cnt !== 16'd1 || bus_n.collision_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL collision_cnt: got b=%0d n=%0d, want 1", bus_b.collision_cnt, bus_n.collision_cnt);
    end
    set_idle();
    bus_b.rden   = 2'b01;
    bus_b.rdaddr = {8'd0, 8'd9};
    advance();
    n_tests++;
    if (bus_b.bank_select[1:0] !== 2'd0 || bus_b.rd_collision[0] !== 1'b1 || bus_b.rd_hit[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_row: got bs=%0d c=%b h=%b, want bs=0 c=1 h=1",
               bus_b.bank_select[1:0], bus_b.rd_collision[0], bus_b.rd_hit[0]);
    end
    set_idle();
    bus_b.wren   = 3'b100;
    bus_b.wraddr = {8'd9, 8'd0, 8'd0};
    advance();
    set_idle();
    bus_b.rden   = 2'b10;
    bus_b.rdaddr = {8'd9, 8'd0};
    advance();
    n_tests++;
    if (bus_n.bank_select[3:2] !== 2'd2 || bus_n.rd_collision[1] !== 1'b0 || bus_n.rd_hit[1] !== 1'b1 ||
        bus_n.collision_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_rewrite: got bs=%0d c=%b h=%b cnt=%0d, want bs=2 c=0 h=1 cnt=1",
               bus_n.bank_select[3:2], bus_n.rd_collision[1], bus_n.rd_hit[1], bus_n.collision_cnt);
    end
  endtask

  task automatic test_bypass();
    set_idle();
    bus_b.wren   = 3'b010;
    bus_b.wraddr = {8'd0, 8'd3, 8'd0};
    bus_b.rden   = 2'b10;
    bus_b.rdaddr = {8'd3, 8'd0};
    advance();
    n_tests++;
    if (bus_b.bank_select[3:2] !== 2'd1 || bus_b.rd_hit[1] !== 1'b1 || bus_b.rd_collision[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_on: got bs=%0d h=%b c=%b, want bs=1 h=1 c=0",
               bus_b.bank_select[3:2], bus_b.rd_hit[1], bus_b.rd_collision[1]);
    end
    n_tests++;
    if (bus_n.bank_select[3:2] !== 2'd0 || bus_n.rd_hit[1] !== 1'b0 || bus_n.rd_collision[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_off: got bs=%0d h=%b c=%b, want bs=0 h=0 c=0",
               bus_n.bank_select[3:2], bus_n.rd_hit[1], bus_n.rd_collision[1]);
    end
    n_tests++;
    if (bus_b.bank_select[1:0] !== 2'd0 || bus_b.rd_collision[0] !== 1'b1 || bus_b.rdvalid !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_port0: got bs=%0d c=%b v=%b, want bs=0 c=1 v=10",
               bus_b.bank_select[1:0], bus_b.rd_collision[0], bus_b.rdvalid);
    end
  endtask

  task automatic test_random(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      bus_b.clear = ($urandom_range(0, 31) == 0);
      bus_b.wren  = NWR'($urandom);
      for (int i = 0; i < NWR; i++) bus_b.wraddr[i*AW +: AW] = pick_addr();
      bus_b.rden  = NRD'($urandom);
      for (int r = 0; r < NRD; r++) bus_b.rdaddr[r*AW +: AW] = pick_addr();
      advance();
      n_tests++;
      if ({bus_b.rdvalid, bus_b.bank_select, bus_b.rd_collision, bus_b.rd_hit, bus_b.collision_cnt} !==
          {e_valid, e_bs_b, e_col_b, e_hit_b, e_cnt}) begin
        n_fail++;
        $display("FAIL random_b cyc%0d: got v=%b bs=%h c=%b h=%b cnt=%0d, want v=%b bs=%h c=%b h=%b cnt=%0d",
                 k, bus_b.rdvalid, bus_b.bank_select, bus_b.rd_collision, bus_b.rd_hit, bus_b.collision_cnt,
                 e_valid, e_bs_b, e_col_b, e_hit_b, e_cnt);
      end
      n_tests++;
      if ({bus_n.rdvalid, bus_n.bank_select, bus_n.rd_collision, bus_n.rd_hit, bus_n.collision_cnt} !==
          {e_valid, e_bs_n, e_col_n, e_hit_n, e_cnt}) begin
        n_fail++;
        $display("FAIL random_n cyc%0d: got v=%b bs=%h c=%b h=%b cnt=%0d, want v=%b bs=%h c=%b h=%b cnt=%0d",
                 k, bus_n.rdvalid, bus_n.bank_select, bus_n.rd_collision, bus_n.rd_hit, bus_n.collision_cnt,
                 e_valid, e_bs_n, e_col_n, e_hit_n, e_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_lookup();
    set_idle();
    bus_b.wren   = 3'b001;
    bus_b.wraddr = {8'd0, 8'd0, 8'd7};
    advance();
    bus_b.wren   = '0;
    bus_b.rden   = 2'b11;
    bus_b.rdaddr = {8'd7, 8'd7};
    advance();
    n_tests++;
    if (bus_b.rdvalid !== 2'b11 || bus_b.rd_hit !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_lookup: got v=%b h=%b, want v=11 h=11", bus_b.rdvalid, bus_b.rd_hit);
    end
    #2;
    aresetn = 1'b0;
    #1;
    n_tests++;
    if ({bus_b.rdvalid, bus_b.bank_select, bus_b.rd_collision, bus_b.rd_hit, bus_b.collision_cnt} !== '0 ||
        {bus_n.rdvalid, bus_n.bank_select, bus_n.rd_collision, bus_n.rd_hit, bus_n.collision_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b/%b h=%b/%b cnt=%0d/%0d, want all zero",
               bus_b.rdvalid, bus_n.rdvalid, bus_b.rd_hit, bus_n.rd_hit, bus_b.collision_cnt, bus_n.collision_cnt);
    end
    #2;
    aresetn = 1'b1;
    model_reset();
    for (int a = 0; a < DEPTH; a += 2) begin
      bus_b.rden   = 2'b11;
      bus_b.rdaddr = {AW'(a + 1), AW'(a)};
      advance();
      n_tests++;
      if (bus_b.rdvalid !== 2'b11 || bus_b.rd_hit !== 2'b00 || bus_n.rd_hit !== 2'b00) begin
        n_fail++;
        $display("FAIL post_reset_row%0d: got v=%b h=%b/%b, want v=11 h=00", a,
                 bus_b.rdvalid, bus_b.rd_hit, bus_n.rd_hit);
      end
    end
  endtask

  task automatic test_saturation();
    set_idle();
    bus_b.wren   = 3'b011;
    bus_b.wraddr = {8'd0, 8'd4, 8'd4};
    for (int k = 0; k < 70000; k++) advance();
    n_tests++;
    if (bus_b.collision_cnt !== 16'hFFFF || bus_n.collision_cnt !== 16'hFFFF || e_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate: got b=%h n=%h model=%h, want FFFF", bus_b.collision_cnt, bus_n.collision_cnt, e_cnt);
    end
    for (int k = 0; k < 3; k++) advance();
    n_tests++;
    if (bus_b.collision_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate_hold: got %h, want FFFF", bus_b.collision_cnt);
    end
    bus_b.clear  = 1'b1;
    bus_b.rden   = 2'b10;
    bus_b.rdaddr = {8'd4, 8'd0};
    advance();
    n_tests++;
    if (bus_b.collision_cnt !== 16'h0 || bus_n.collision_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL clear_cnt: got b=%h n=%h, want 0", bus_b.collision_cnt, bus_n.collision_cnt);
    end
    n_tests++;
    if (bus_b.bank_select[3:2] !== 2'd0 || bus_b.rd_collision[1] !== 1'b1 || bus_b.rd_hit[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_read_pre: got bs=%0d c=%b h=%b, want bs=0 c=1 h=1",
               bus_b.bank_select[3:2], bus_b.rd_collision[1], bus_b.rd_hit[1]);
    end
    set_idle();
    bus_b.rden   = 2'b11;
    bus_b.rdaddr = {8'd4, 8'd4};
    advance();
    n_tests++;
    if (bus_b.rd_hit !== 2'b00 || bus_n.rd_hit !== 2'b00 || bus_b.rd_collision !== 2'b00 ||
        bus_b.collision_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL clear_row4: got h=%b/%b c=%b cnt=%h, want h=00 c=00 cnt=0",
               bus_b.rd_hit, bus_n.rd_hit, bus_b.rd_collision, bus_b.collision_cnt);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_read();
    test_collision();
    test_bypass();
    test_random(1500);
    test_reset_mid_lookup();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
